// File: rtl/pmod_stand_spi_solo_arbiter.sv
// -----------------------------------------------------------------------------
// pmod_stand_spi_solo_arbiter
//   Round-robin lock arbiter that lets two PMOD drivers (requester 0 = ACL2,
//   requester 1 = CLS) share one standard-SPI solo master. The winner owns the
//   master for a whole command (TX enqueue, go, RX dequeue); its strobes and
//   command geometry are muxed through, and the loser sees all-zero status.
//
//   Optional feature macro: PMOD_SPI_ARB_TIMEOUT_EN
//     defined   -> lock-hold watchdog (TIMEOUT_CYC idle-bus clocks) forces a
//                  release; the evicted requester must drop its lock once
//                  before it may request again.
//     undefined -> ownership ends only when the owner drops its lock.
// -----------------------------------------------------------------------------
module pmod_stand_spi_solo_arbiter #(
    parameter int TX_LEN_BITS   = 11,
    parameter int WAIT_CYC_BITS = 2,
    parameter int RX_LEN_BITS   = 11
`ifdef PMOD_SPI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC   = 4096
`endif
) (
    input  logic                       i_ext_spi_clk_x,
    input  logic                       i_srst,

    // requester side
    input  logic [1:0]                 i_req_lock,
    output logic [1:0]                 o_req_grant,
    input  logic [1:0]                 i_req_go_stand,
    input  logic [2*TX_LEN_BITS-1:0]   i_req_tx_len,
    input  logic [2*WAIT_CYC_BITS-1:0] i_req_wait_cyc,
    input  logic [2*RX_LEN_BITS-1:0]   i_req_rx_len,
    input  logic [15:0]                i_req_tx_data,
    input  logic [1:0]                 i_req_tx_enqueue,
    output logic [1:0]                 o_req_tx_ready,
    input  logic [1:0]                 i_req_rx_dequeue,
    output logic [7:0]                 o_req_rx_data,
    output logic [1:0]                 o_req_rx_valid,
    output logic [1:0]                 o_req_rx_avail,
    output logic [1:0]                 o_req_spi_idle,

    // master side
    output logic                       o_go_stand,
    output logic [TX_LEN_BITS-1:0]     o_tx_len,
    output logic [WAIT_CYC_BITS-1:0]   o_wait_cyc,
    output logic [RX_LEN_BITS-1:0]     o_rx_len,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_enqueue,
    input  logic                       i_tx_ready,
    output logic                       o_rx_dequeue,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_rx_avail,
    input  logic                       i_spi_idle
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [1:0] grant, grant_next;
    logic       last_owner, last_owner_next;
    logic       winner;

    // The grant is one-hot whenever it is non-zero, so bit 1 names the owner.
    logic       owner;
    logic       owner_lock;
    logic       owned;
    logic [1:0] lock_eff;
    logic       timeout_hit;

    assign owner       = grant[1];
    assign owner_lock  = owner ? i_req_lock[1] : i_req_lock[0];
    assign owned       = (state == ST_OWNED);
    assign o_req_grant = grant;

`ifdef PMOD_SPI_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;
    logic [1:0]      to_block;

    // The watchdog fires on the TIMEOUT_CYC-th idle-bus cycle of one ownership.
    assign timeout_hit = owned && i_spi_idle && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // A requester evicted by the watchdog stays masked until it drops its lock.
    assign lock_eff = i_req_lock & ~to_block;

    // Watchdog counter (cleared while unowned, saturating) and eviction mask.
    always_ff @(posedge i_ext_spi_clk_x) begin
        if (i_srst) begin
            to_cnt   <= '0;
            to_block <= 2'b00;
        end else begin
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (owned && i_spi_idle && (to_cnt != '1)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            to_block <= (to_block & i_req_lock) | ({2{timeout_hit}} & grant);
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign lock_eff    = i_req_lock;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge i_ext_spi_clk_x) begin
        if (i_srst) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;            // requester 0 wins the first tie
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of the others.
            state      <= state_next;
            grant      <= grant_next;
            last_owner <= last_owner_next;
        end
    end

    // Next-state logic: grant from idle, release on lock drop, clear once idle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next      = state;
        grant_next      = grant;
        last_owner_next = last_owner;
        winner          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_spi_idle && (lock_eff != 2'b00)) begin
                    winner          = (lock_eff == 2'b11) ? ~last_owner : lock_eff[1];
                    grant_next      = winner ? 2'b10 : 2'b01;
                    last_owner_next = winner;
                    state_next      = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_lock || timeout_hit) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Hold the grant until the master has finished any command
                // the owner left behind.
                if (i_spi_idle) begin
                    state_next = ST_IDLE;
                    grant_next = 2'b00;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    // Owner-to-master mux; everything toward the master is zero unless owned.
    always_comb begin
        o_go_stand   = 1'b0;
        o_tx_len     = '0;
        o_wait_cyc   = '0;
        o_rx_len     = '0;
        o_tx_data    = 8'h00;
        o_tx_enqueue = 1'b0;
        o_rx_dequeue = 1'b0;

        if (owned) begin
            if (owner) begin
                o_go_stand   = i_req_go_stand[1];
                o_tx_len     = i_req_tx_len[2*TX_LEN_BITS-1:TX_LEN_BITS];
                o_wait_cyc   = i_req_wait_cyc[2*WAIT_CYC_BITS-1:WAIT_CYC_BITS];
                o_rx_len     = i_req_rx_len[2*RX_LEN_BITS-1:RX_LEN_BITS];
                o_tx_data    = i_req_tx_data[15:8];
                o_tx_enqueue = i_req_tx_enqueue[1];
                o_rx_dequeue = i_req_rx_dequeue[1];
            end else begin
                o_go_stand   = i_req_go_stand[0];
                o_tx_len     = i_req_tx_len[TX_LEN_BITS-1:0];
                o_wait_cyc   = i_req_wait_cyc[WAIT_CYC_BITS-1:0];
                o_rx_len     = i_req_rx_len[RX_LEN_BITS-1:0];
                o_tx_data    = i_req_tx_data[7:0];
                o_tx_enqueue = i_req_tx_enqueue[0];
                o_rx_dequeue = i_req_rx_dequeue[0];
            end
        end
    end

    // Master status goes only to the owner bit; the loser always reads zero.
    logic [1:0] status_mask;

    assign status_mask    = owned ? grant : 2'b00;
    assign o_req_tx_ready = status_mask & {2{i_tx_ready}};
    assign o_req_rx_valid = status_mask & {2{i_rx_valid}};
    assign o_req_rx_avail = status_mask & {2{i_rx_avail}};
    assign o_req_spi_idle = status_mask & {2{i_spi_idle}};

    // RX data is shared by both requesters and qualified by o_req_rx_valid.
    assign o_req_rx_data  = owned ? i_rx_data : 8'h00;

endmodule

// File: tb/tb_pmod_stand_spi_solo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmod_stand_spi_solo_arbiter
//   Directed scenarios followed by randomized traffic. The driver computes the
//   expected outputs of each cycle from a behavioural ownership model and
//   queues them; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_pmod_stand_spi_solo_arbiter;

    localparam int TXB = 11;
    localparam int WCB = 2;
    localparam int RXB = 11;

    logic              clk = 1'b0;
    logic              i_srst;
    logic [1:0]        i_req_lock;
    logic [1:0]        o_req_grant;
    logic [1:0]        i_req_go_stand;
    logic [2*TXB-1:0]  i_req_tx_len;
    logic [2*WCB-1:0]  i_req_wait_cyc;
    logic [2*RXB-1:0]  i_req_rx_len;
    logic [15:0]       i_req_tx_data;
    logic [1:0]        i_req_tx_enqueue;
    logic [1:0]        o_req_tx_ready;
    logic [1:0]        i_req_rx_dequeue;
    logic [7:0]        o_req_rx_data;
    logic [1:0]        o_req_rx_valid;
    logic [1:0]        o_req_rx_avail;
    logic [1:0]        o_req_spi_idle;
    logic              o_go_stand;
    logic [TXB-1:0]    o_tx_len;
    logic [WCB-1:0]    o_wait_cyc;
    logic [RXB-1:0]    o_rx_len;
    logic [7:0]        o_tx_data;
    logic              o_tx_enqueue;
    logic              i_tx_ready;
    logic              o_rx_dequeue;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              i_rx_avail;
    logic              i_spi_idle;

    always #5 clk = ~clk;

    pmod_stand_spi_solo_arbiter dut (
        .i_ext_spi_clk_x  (clk),
        .i_srst           (i_srst),
        .i_req_lock       (i_req_lock),
        .o_req_grant      (o_req_grant),
        .i_req_go_stand   (i_req_go_stand),
        .i_req_tx_len     (i_req_tx_len),
        .i_req_wait_cyc   (i_req_wait_cyc),
        .i_req_rx_len     (i_req_rx_len),
        .i_req_tx_data    (i_req_tx_data),
        .i_req_tx_enqueue (i_req_tx_enqueue),
        .o_req_tx_ready   (o_req_tx_ready),
        .i_req_rx_dequeue (i_req_rx_dequeue),
        .o_req_rx_data    (o_req_rx_data),
        .o_req_rx_valid   (o_req_rx_valid),
        .o_req_rx_avail   (o_req_rx_avail),
        .o_req_spi_idle   (o_req_spi_idle),
        .o_go_stand       (o_go_stand),
        .o_tx_len         (o_tx_len),
        .o_wait_cyc       (o_wait_cyc),
        .o_rx_len         (o_rx_len),
        .o_tx_data        (o_tx_data),
        .o_tx_enqueue     (o_tx_enqueue),
        .i_tx_ready       (i_tx_ready),
        .o_rx_dequeue     (o_rx_dequeue),
        .i_rx_data        (i_rx_data),
        .i_rx_valid       (i_rx_valid),
        .i_rx_avail       (i_rx_avail),
        .i_spi_idle       (i_spi_idle)
    );

    typedef struct packed {
        logic [1:0]     grant;
        logic           go;
        logic [TXB-1:0] tx_len;
        logic [WCB-1:0] wait_cyc;
        logic [RXB-1:0] rx_len;
        logic [7:0]     tx_data;
        logic           tx_enq;
        logic           rx_deq;
        logic [1:0]     req_tx_ready;
        logic [1:0]     req_rx_valid;
        logic [1:0]     req_rx_avail;
        logic [1:0]     req_spi_idle;
        logic [7:0]     rx_data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: who holds the bus (-1 = nobody), whether that owner
    // has let go and we are waiting for the master to go idle, and who won last.
    int m_owner   = -1;
    bit m_leaving = 1'b0;
    int m_last    = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive, queue the expected response, advance model.
    task automatic drive_cycle(input logic [1:0] lock, input logic [1:0] go,
                               input logic [1:0] enq, input logic [1:0] deq,
                               input logic idle, input logic rst);
        exp_t e;
        bit   forwarding;
        int   o;
        int   w;
        @(negedge clk);
        i_srst           = rst;
        i_req_lock       = lock;
        i_req_go_stand   = go;
        i_req_tx_enqueue = enq;
        i_req_rx_dequeue = deq;
        i_spi_idle       = idle;
        i_req_tx_len     = 22'($urandom);
        i_req_wait_cyc   = 4'($urandom);
        i_req_rx_len     = 22'($urandom);
        i_req_tx_data    = 16'($urandom);
        i_rx_data        = 8'($urandom);
        i_tx_ready       = 1'($urandom);
        i_rx_valid       = 1'($urandom);
        i_rx_avail       = 1'($urandom);

        e          = '0;
        forwarding = (m_owner >= 0) && !m_leaving;
        o          = (m_owner < 0) ? 0 : m_owner;
        if (m_owner >= 0) e.grant = 2'(1 << m_owner);
        if (forwarding) begin
            e.go              = go[o];
            e.tx_len          = i_req_tx_len[o*TXB +: TXB];
            e.wait_cyc        = i_req_wait_cyc[o*WCB +: WCB];
            e.rx_len          = i_req_rx_len[o*RXB +: RXB];
            e.tx_data         = i_req_tx_data[o*8 +: 8];
            e.tx_enq          = enq[o];
            e.rx_deq          = deq[o];
            e.req_tx_ready[o] = i_tx_ready;
            e.req_rx_valid[o] = i_rx_valid;
            e.req_rx_avail[o] = i_rx_avail;
            e.req_spi_idle[o] = idle;
            e.rx_data         = i_rx_data;
        end
        exp_q.push_back(e);

        if (rst) begin
            m_owner   = -1;
            m_leaving = 1'b0;
            m_last    = 1;
        end else if (m_owner < 0) begin
            if (idle && (lock != 2'b00)) begin
                if (lock == 2'b11) w = 1 - m_last;
                else               w = lock[1] ? 1 : 0;
                m_owner   = w;
                m_last    = w;
                m_leaving = 1'b0;
            end
        end else if (!m_leaving) begin
            if (!lock[m_owner]) m_leaving = 1'b1;
        end else if (idle) begin
            m_owner   = -1;
            m_leaving = 1'b0;
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grant",        32'(o_req_grant),    32'(e.grant));
                check("go_stand",     32'(o_go_stand),     32'(e.go));
                check("tx_len",       32'(o_tx_len),       32'(e.tx_len));
                check("wait_cyc",     32'(o_wait_cyc),     32'(e.wait_cyc));
                check("rx_len",       32'(o_rx_len),       32'(e.rx_len));
                check("tx_data",      32'(o_tx_data),      32'(e.tx_data));
                check("tx_enqueue",   32'(o_tx_enqueue),   32'(e.tx_enq));
                check("rx_dequeue",   32'(o_rx_dequeue),   32'(e.rx_deq));
                check("req_tx_ready", 32'(o_req_tx_ready), 32'(e.req_tx_ready));
                check("req_rx_valid", 32'(o_req_rx_valid), 32'(e.req_rx_valid));
                check("req_rx_avail", 32'(o_req_rx_avail), 32'(e.req_rx_avail));
                check("req_spi_idle", 32'(o_req_spi_idle), 32'(e.req_spi_idle));
                check("req_rx_data",  32'(o_req_rx_data),  32'(e.rx_data));
            end
        end
    end

    initial begin : stimulus
        logic [1:0] lock_r;
        i_srst = 1'b1; i_req_lock = 2'b00; i_req_go_stand = 2'b00;
        i_req_tx_len = '0; i_req_wait_cyc = '0; i_req_rx_len = '0;
        i_req_tx_data = '0; i_req_tx_enqueue = 2'b00; i_req_rx_dequeue = 2'b00;
        i_tx_ready = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0;
        i_rx_avail = 1'b0; i_spi_idle = 1'b1;
        repeat (2) @(posedge clk);

        // Sole requester 0: grant one clock later, go forwarded same cycle.
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        drive_cycle(2'b00, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Tie right after reset goes to requester 0, then alternates to 1.
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        drive_cycle(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b11, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0);
        drive_cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        // Owner is requester 1; loser strobes are dropped.
        drive_cycle(2'b11, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        drive_cycle(2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Requester 0 drops its lock while the master stays busy for 20 clocks.
        drive_cycle(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Reset while owned with go pending.
        drive_cycle(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_cycle(2'b10, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
        drive_cycle(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        drive_cycle(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Randomized traffic with sticky locks and a mostly idle master.
        lock_r = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) lock_r[0] = ~lock_r[0];
            if ($urandom_range(7) == 0) lock_r[1] = ~lock_r[1];
            drive_cycle(lock_r, 2'($urandom), 2'($urandom), 2'($urandom),
                        ($urandom_range(3) != 0), ($urandom_range(399) == 0));
        end

        @(negedge clk);
        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
